// File: rtl/gt_producer.sv
// Windowed above-threshold sample counter feeding the control block's gt/t_g_gt interface.
// Optional ack timeout enabled by defining GT_PRODUCER_TIMEOUT_EN.
module gt_producer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] thr,
    input  logic [7:0]       lim,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             ack,
    output logic [7:0]       gt,
    output logic             t_g_gt,
    output logic             gt_valid,
    output logic             busy,
    output logic             err
);

    if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
        $error("gt_producer: WINDOW must be in 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("gt_producer: TIMEOUT must be in 1..255");
    end

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_thr,   w_thr_nxt;
    logic [7:0]       r_lim,   w_lim_nxt;
    logic [7:0]       r_count, w_count_nxt;
    logic [7:0]       r_idx,   w_idx_nxt;
    logic [7:0]       r_gt,    w_gt_nxt;
    logic             r_tgt,   w_tgt_nxt;
    logic             r_gtv,   w_gtv_nxt;
    logic             w_hit;
    logic [7:0]       w_count_acc;

`ifdef GT_PRODUCER_TIMEOUT_EN
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
    logic [7:0] r_wait, w_wait_nxt;
    logic       r_err,  w_err_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_thr   <= '0;
            r_lim   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_gt    <= '0;
            r_tgt   <= 1'b0;
            r_gtv   <= 1'b0;
`ifdef GT_PRODUCER_TIMEOUT_EN
            r_wait  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_thr   <= w_thr_nxt;
            r_lim   <= w_lim_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_gt    <= w_gt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_gtv   <= w_gtv_nxt;
`ifdef GT_PRODUCER_TIMEOUT_EN
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    // Saturating count including the sample on the current cycle.
    always_comb begin
        w_hit       = (din > r_thr);
        w_count_acc = (w_hit && (r_count != 8'hFF)) ? r_count + 8'd1 : r_count;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_thr_nxt   = r_thr;
        w_lim_nxt   = r_lim;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_gt_nxt    = r_gt;
        w_tgt_nxt   = r_tgt;
        w_gtv_nxt   = r_gtv;
`ifdef GT_PRODUCER_TIMEOUT_EN
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_thr_nxt   = thr;
                    w_lim_nxt   = lim;
                    w_count_nxt = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (din_valid) begin
                    w_count_nxt = w_count_acc;
                    w_idx_nxt   = r_idx + 8'd1;
                    if (r_idx == LAST_IDX) begin
                        w_gt_nxt    = w_count_acc;
                        w_tgt_nxt   = (w_count_acc > r_lim);
                        w_gtv_nxt   = 1'b1;
                        w_state_nxt = PRESENT;
`ifdef GT_PRODUCER_TIMEOUT_EN
                        w_wait_nxt  = '0;
`endif
                    end
                end
            end
            PRESENT: begin
                if (ack) begin
                    w_gt_nxt    = '0;
                    w_tgt_nxt   = 1'b0;
                    w_gtv_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
`ifdef GT_PRODUCER_TIMEOUT_EN
                // ack on the final wait cycle takes priority over the timeout.
                else if (r_wait == LAST_WAIT) begin
                    w_gt_nxt    = '0;
                    w_tgt_nxt   = 1'b0;
                    w_gtv_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gt       = r_gt;
    assign t_g_gt   = r_tgt;
    assign gt_valid = r_gtv;
    assign busy     = (r_state != IDLE);
`ifdef GT_PRODUCER_TIMEOUT_EN
    assign err      = r_err;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_gt_producer.sv
// Directed + randomized bench for gt_producer using three instances (WINDOW = 16, 255, 1).
// Expected results come from a counting model over each window's sample list.
module tb_gt_producer;

    logic       clk = 1'b0;
    logic       rst, start, ack, din_valid;
    logic [7:0] thr, lim, din;
    int         sel;
    logic [2:0] start_v;

    logic [7:0] gt_w   [3];
    logic       tgt_w  [3];
    logic       gtv_w  [3];
    logic       busy_w [3];
    logic       err_w  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Only the selected instance ever sees start, so the others stay idle.
    assign start_v[0] = start && (sel == 0);
    assign start_v[1] = start && (sel == 1);
    assign start_v[2] = start && (sel == 2);

    gt_producer #(.WIDTH(8), .WINDOW(16), .TIMEOUT(32)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[0]), .thr(thr), .lim(lim),
        .din(din), .din_valid(din_valid), .ack(ack),
        .gt(gt_w[0]), .t_g_gt(tgt_w[0]), .gt_valid(gtv_w[0]), .busy(busy_w[0]), .err(err_w[0]));

    gt_producer #(.WIDTH(8), .WINDOW(255), .TIMEOUT(32)) u_w255 (
        .clk(clk), .rst(rst), .start(start_v[1]), .thr(thr), .lim(lim),
        .din(din), .din_valid(din_valid), .ack(ack),
        .gt(gt_w[1]), .t_g_gt(tgt_w[1]), .gt_valid(gtv_w[1]), .busy(busy_w[1]), .err(err_w[1]));

    gt_producer #(.WIDTH(8), .WINDOW(1), .TIMEOUT(32)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .thr(thr), .lim(lim),
        .din(din), .din_valid(din_valid), .ack(ack),
        .gt(gt_w[2]), .t_g_gt(tgt_w[2]), .gt_valid(gtv_w[2]), .busy(busy_w[2]), .err(err_w[2]));

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gt"},       {24'd0, gt_w[sel]},   32'd0);
        chk({tag, ".t_g_gt"},   {31'd0, tgt_w[sel]},  32'd0);
        chk({tag, ".gt_valid"}, {31'd0, gtv_w[sel]},  32'd0);
        chk({tag, ".busy"},     {31'd0, busy_w[sel]}, 32'd0);
        chk({tag, ".err"},      {31'd0, err_w[sel]},  32'd0);
    endtask

    function automatic int unsigned model_count(input logic [7:0] s[$], input logic [7:0] t);
        int unsigned c = 0;
        foreach (s[i]) if (s[i] > t) c++;
        return (c > 255) ? 255 : c;
    endfunction

    // Runs one window on instance d; optionally stalls, delays ack, and holds start for back-to-back.
    task automatic run_window(input int d, input logic [7:0] t, input logic [7:0] l,
                              input logic [7:0] s[$], input bit stall, input int unsigned ack_delay,
                              input bit pre_started, input bit hold_start, input string tag);
        int unsigned exp_gt;
        bit          exp_tgt;
        exp_gt  = model_count(s, t);
        exp_tgt = (exp_gt > int'(l));
        sel = d;
        if (!pre_started) begin
            thr = t; lim = l; start = 1'b1;
            tick;
            start = hold_start;
            chk({tag, ".busy_after_start"}, {31'd0, busy_w[sel]}, 32'd1);
        end
        for (int i = 0; i < s.size(); i++) begin
            if (stall) begin
                din_valid = 1'b0; din = 8'hFF; ack = 1'b1;
                tick;
                ack = 1'b0;
            end
            din = s[i]; din_valid = 1'b1;
            if (i == s.size() - 1)
                chk({tag, ".valid_before_last"}, {31'd0, gtv_w[sel]}, 32'd0);
            tick;
        end
        din_valid = 1'b0;
        chk({tag, ".gt_valid"}, {31'd0, gtv_w[sel]},  32'd1);
        chk({tag, ".gt"},       {24'd0, gt_w[sel]},   exp_gt);
        chk({tag, ".t_g_gt"},   {31'd0, tgt_w[sel]},  {31'd0, exp_tgt});
        chk({tag, ".busy"},     {31'd0, busy_w[sel]}, 32'd1);
        chk({tag, ".err"},      {31'd0, err_w[sel]},  32'd0);
        for (int k = 0; k < int'(ack_delay); k++) begin
            start = 1'b1; din_valid = 1'b1; din = 8'($urandom);
            tick;
            chk({tag, ".hold_gt"},    {24'd0, gt_w[sel]},  exp_gt);
            chk({tag, ".hold_tgt"},   {31'd0, tgt_w[sel]}, {31'd0, exp_tgt});
            chk({tag, ".hold_valid"}, {31'd0, gtv_w[sel]}, 32'd1);
        end
        din_valid = 1'b0;
        start = 1'b1; ack = 1'b1;
        tick;
        ack = 1'b0; start = hold_start;
        chk_idle({tag, ".after_ack"});
        tick;
        chk({tag, ".busy_next"}, {31'd0, busy_w[sel]}, {31'd0, hold_start});
        if (hold_start)
            chk({tag, ".b2b_valid"}, {31'd0, gtv_w[sel]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        rst = 1'b0; start = 1'b0; ack = 1'b0; din_valid = 1'b0;
        din = '0; thr = '0; lim = '0; sel = 0;
        #2;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            chk_idle("reset_init");
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b1;
        tick;

        // Abort mid-window with asynchronous reset.
        thr = 8'h80; lim = 8'd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 8'hFF; din_valid = 1'b1;
            tick;
        end
        rst = 1'b0;
        #1;
        chk_idle("reset_mid_accum");
        tick;
        tick;
        chk_idle("reset_held");
        din_valid = 1'b0;
        rst = 1'b1;
        tick;
        chk_idle("reset_released");
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'h00);
        run_window(0, 8'h80, 8'd5, q, 1'b0, 0, 1'b0, 1'b0, "post_reset");

        q = {};
        for (int i = 0; i < 16; i++) q.push_back((i % 2 == 0) ? 8'h90 : 8'h10);
        run_window(0, 8'h80, 8'd5, q, 1'b0, 0, 1'b0, 1'b0, "basic");
        run_window(0, 8'h80, 8'd5, q, 1'b1, 10, 1'b0, 1'b0, "stall_hold");

        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'h80);
        run_window(0, 8'h80, 8'd5, q, 1'b0, 1, 1'b0, 1'b0, "thr_equal");

        q = {};
        for (int i = 0; i < 16; i++) q.push_back((i < 8) ? 8'hFF : 8'h00);
        run_window(0, 8'h10, 8'd8, q, 1'b0, 0, 1'b0, 1'b0, "lim_equal");

        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        run_window(0, 8'hFF, 8'd0, q, 1'b0, 0, 1'b0, 1'b0, "thr_max");

        for (int r = 0; r < 6; r++) begin
            q = {};
            for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
            run_window(0, 8'($urandom), 8'($urandom_range(0, 16)), q,
                       1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0, "rand16");
        end

        q = {8'h90};
        run_window(2, 8'h80, 8'd0, q, 1'b0, 0, 1'b0, 1'b0, "win1_hit");
        for (int r = 0; r < 4; r++) begin
            q = {8'($urandom)};
            run_window(2, 8'($urandom), 8'($urandom_range(0, 1)), q,
                       1'($urandom), $urandom_range(0, 2), 1'b0, 1'b0, "win1_rand");
        end

        // Saturation, then back-to-back restart with start held high through ack.
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'hFF);
        run_window(1, 8'h00, 8'd254, q, 1'b0, 2, 1'b0, 1'b1, "sat");
        start = 1'b0;
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'($urandom));
        run_window(1, 8'h00, 8'd254, q, 1'b0, 0, 1'b1, 1'b0, "b2b");
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'hFF);
        run_window(1, 8'h00, 8'd255, q, 1'b0, 0, 1'b0, 1'b0, "lim_max");

`ifdef GT_PRODUCER_TIMEOUT_EN
        sel = 0;
        for (int pass = 0; pass < 2; pass++) begin
            thr = 8'h80; lim = 8'd5; start = 1'b1;
            tick;
            start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                din = (i % 2 == 0) ? 8'h90 : 8'h10; din_valid = 1'b1;
                tick;
            end
            din_valid = 1'b0;
            for (int k = 0; k < 31; k++) begin
                tick;
                chk("to_wait_valid", {31'd0, gtv_w[0]}, 32'd1);
            end
            ack = (pass == 0);
            tick;
            ack = 1'b0;
            chk("to_gt",    {24'd0, gt_w[0]},   32'd0);
            chk("to_valid", {31'd0, gtv_w[0]},  32'd0);
            chk("to_busy",  {31'd0, busy_w[0]}, 32'd0);
            chk("to_err",   {31'd0, err_w[0]},  (pass == 0) ? 32'd0 : 32'd1);
            tick;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
